cook_program_sequencer: RTL and testbench
=========================================

COOK_PROGRAM_SEQUENCER -- requirements
Module: cook_program_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, SHALL set the number of programmable cook stages (2..4).
REQ-002 Parameter ALARM_SECS, default 3, SHALL set the number of 1 Hz ticks the inter-stage alarm is asserted.
REQ-003 Port list (name, direction, width, meaning):
- CLK100MHZ, in, 1: single system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- pulse_1Hz, in, 1: one-cycle tick.
- start, in, 1: debounced one-cycle request.
- abort, in, 1: one-cycle cancel.
- prog_we, in, 1: stage write strobe.
- prog_addr, in, 2: stage index.
- prog_data, in, 16: BCD mm:ss {min_tens, min_ones, sec_tens, sec_ones}.
- prog_err, out, 1: one-cycle rejected-write flag.
- timer_zero, in, 1: timer datapath reads 00:00.
- timer_load, out, 1: one-cycle load strobe to timer.
- load_bcd, out, 16: value to load.
- timer_enable, out, 1: countdown enable.
- stage_idx, out, 2: current stage.
- busy, out, 1: program active.
- paused, out, 1: countdown held.
- alarm, out, 1: inter-stage or final alarm.
- done, out, 1: program complete.

Function
REQ-004 FSM states: IDLE, LOAD, RUN, PAUSE, ALARM, DONE.
REQ-005 Writes SHALL be accepted only in IDLE with prog_addr < NUM_STAGES.
REQ-006 A write SHALL be rejected, with prog_err pulsed for one cycle and the stage unchanged, if any digit is >9 or sec_tens is >5.
REQ-007 Writes outside IDLE SHALL be ignored silently, with no prog_err.
REQ-008 A stored value of 0000 SHALL mark the end of the program.
REQ-009 IDLE: on start with stage[0] != 0, stage_idx SHALL be set to 0 and the FSM SHALL go to LOAD; start with stage[0] == 0 SHALL be ignored.
REQ-010 LOAD: timer_load=1 and load_bcd=stage[stage_idx] SHALL be driven for exactly one cycle, then the FSM SHALL go to RUN.
REQ-011 RUN: timer_enable=1. timer_zero SHALL be ignored in the first RUN cycle (load settling). Thereafter timer_zero=1 SHALL go to ALARM with the tick counter cleared.
REQ-012 RUN: start with timer_zero=0 SHALL go to PAUSE. If start and timer_zero coincide, timer_zero SHALL win and the FSM SHALL go to ALARM.
REQ-013 PAUSE: timer_enable=0 and paused=1; start SHALL return to RUN without a reload.
REQ-014 ALARM: alarm=1 and timer_enable=0; each pulse_1Hz SHALL increment the tick counter.
REQ-015 On the ALARM_SECS-th tick: if stage_idx == NUM_STAGES-1 or stage[stage_idx+1] == 0, the FSM SHALL go to DONE; otherwise stage_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-016 DONE: done=1 and alarm SHALL toggle on each pulse_1Hz; start or abort SHALL go to IDLE.
REQ-017 abort SHALL go to IDLE from any state on the next edge, with all outputs at reset values and stored stages retained; abort SHALL beat a simultaneous start.
REQ-018 busy SHALL be 1 in LOAD, RUN, PAUSE and ALARM, and 0 otherwise.
REQ-019 Outputs SHALL be registered, with one-cycle latency from the causing input.

Reset
REQ-020 Assertion of reset_n low SHALL asynchronously force IDLE, stage_idx=0, the tick counter to 0, all stages to 0000, and all outputs to 0 (load_bcd=0000).
REQ-021 Release of reset_n SHALL take effect synchronously, with the first transition on the following CLK100MHZ edge.

Structure
REQ-022 Package egg_timer_pkg SHALL hold the FSM state encoding, the BCD time width (16), and the NUM_STAGES and ALARM_SECS defaults.
REQ-023 The stage storage and BCD validity check SHALL be one sub-module, cook_stage_regfile, with its write port inputs, a prog_err output and a combinational read by index.

Verification
REQ-024 Write 0130 to stage0 and 0045 to stage1, then start -> timer_load with load_bcd=0130 two cycles later; after timer_zero, alarm is high for 3 ticks, then timer_load with 0045 and stage_idx=1.
REQ-025 Write 0075 or 0A00 -> prog_err pulses for one cycle and the stage still reads its previous value; a write while busy produces no prog_err and no change.
REQ-026 In RUN, start -> paused=1 and timer_enable=0; a second start -> RUN with no timer_load.
REQ-027 Start and timer_zero in the same RUN cycle -> ALARM, not PAUSE; abort and start together in IDLE -> stays IDLE.
REQ-028 Program all 4 stages, run to the end -> DONE after stage 3 with alarm toggling each tick; start -> IDLE with done=0.
REQ-029 Assert reset_n low mid-RUN, asynchronous to the clock -> outputs are 0 immediately; start after release is ignored because the stages were cleared.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: shared FSM encoding, BCD width, sequencer defaults and BCD digit check
package egg_timer_pkg;
  localparam int BCD_W = 16;
  localparam int NUM_STAGES_DEF = 4;
  localparam int ALARM_SECS_DEF = 3;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, ALARM, DONE} state_t;
  // mm:ss as {min_tens, min_ones, sec_tens, sec_ones}; seconds tens may not exceed 5
  function automatic logic bcd_ok(input logic [BCD_W-1:0] v);
    return v[15:12] <= 4'd9 && v[11:8] <= 4'd9 && v[7:4] <= 4'd5 && v[3:0] <= 4'd9;
  endfunction
endpackage

// File: rtl/cook_program_sequencer_if.sv
// cook_program_sequencer_if: programming port, 1 Hz tick, user controls and timer datapath link
//   master drives ticks/controls/programming/timer_zero; slave (the sequencer) drives status and timer control
interface cook_program_sequencer_if;
  import egg_timer_pkg::*;
  logic             pulse_1Hz;
  logic             start;
  logic             abort;
  logic             prog_we;
  logic [1:0]       prog_addr;
  logic [BCD_W-1:0] prog_data;
  logic             prog_err;
  logic             timer_zero;
  logic             timer_load;
  logic [BCD_W-1:0] load_bcd;
  logic             timer_enable;
  logic [1:0]       stage_idx;
  logic             busy;
  logic             paused;
  logic             alarm;
  logic             done;
  modport master (
    output pulse_1Hz, start, abort, prog_we, prog_addr, prog_data, timer_zero,
    input  prog_err, timer_load, load_bcd, timer_enable, stage_idx, busy, paused, alarm, done
  );
  modport slave (
    input  pulse_1Hz, start, abort, prog_we, prog_addr, prog_data, timer_zero,
    output prog_err, timer_load, load_bcd, timer_enable, stage_idx, busy, paused, alarm, done
  );
endinterface

// File: rtl/cook_stage_regfile.sv
// cook_stage_regfile: stage time storage with BCD validation on write
//   we/addr/data: write port (caller gates it to IDLE); prog_err: registered reject pulse
//   rd_idx: read index; rd_data: stage[rd_idx]; nxt_data: stage[rd_idx+1]
module cook_stage_regfile
  import egg_timer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic             CLK100MHZ,
  input  logic             reset_n,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [BCD_W-1:0] data,
  output logic             prog_err,
  input  logic [1:0]       rd_idx,
  output logic [BCD_W-1:0] rd_data,
  output logic [BCD_W-1:0] nxt_data
);
  // four slots always exist so unused ones read back as 0000 (end of program)
  logic [BCD_W-1:0] stg [4];
  logic hit;
  assign hit = we && int'(addr) < NUM_STAGES;
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) stg[i] <= '0;
      prog_err <= 1'b0;
    end else begin
      prog_err <= hit && !bcd_ok(data);
      if (hit && bcd_ok(data)) stg[addr] <= data;
    end
  assign rd_data  = stg[rd_idx];
  assign nxt_data = stg[rd_idx + 2'd1];
endmodule

// File: rtl/cook_program_sequencer.sv
// cook_program_sequencer: runs up to NUM_STAGES programmed cook times with alarms between stages
//   CLK100MHZ/reset_n: clock and async active-low reset; bus: slave side of cook_program_sequencer_if
//   all status/timer outputs are registered decodes of the state held during the previous cycle
module cook_program_sequencer
  import egg_timer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int ALARM_SECS = ALARM_SECS_DEF
) (
  input  logic CLK100MHZ,
  input  logic reset_n,
  cook_program_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] tick, tick_n;
  logic settle, settle_n;
  logic last, wr_en;
  logic [BCD_W-1:0] cur_bcd, nxt_bcd, load_q;
  logic load_stb_q, en_q, busy_q, paused_q, alarm_q, done_q;
  logic [1:0] idx_q;
  assign wr_en = bus.prog_we && state == IDLE && !bus.abort;
  cook_stage_regfile #(.NUM_STAGES(NUM_STAGES)) u_regfile (
    .CLK100MHZ(CLK100MHZ),
    .reset_n  (reset_n),
    .we       (wr_en),
    .addr     (bus.prog_addr),
    .data     (bus.prog_data),
    .prog_err (bus.prog_err),
    .rd_idx   (idx),
    .rd_data  (cur_bcd),
    .nxt_data (nxt_bcd)
  );
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      tick   <= '0;
      settle <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      tick   <= tick_n;
      settle <= settle_n;
    end
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    tick_n   = tick;
    settle_n = 1'b0;
    last     = int'(idx) == NUM_STAGES - 1 || nxt_bcd == '0;
    if (bus.abort) begin
      state_n = IDLE;
      idx_n   = '0;
      tick_n  = '0;
    end else
      case (state)
        IDLE:  if (bus.start && cur_bcd != '0) begin
                 state_n = LOAD;
                 idx_n   = '0;
               end
        LOAD:  begin
                 state_n  = RUN;
                 settle_n = 1'b1;
               end
        // the first RUN cycle still sees the previous timer contents, so timer_zero is ignored there
        RUN:   if (!settle && bus.timer_zero) begin
                 state_n = ALARM;
                 tick_n  = '0;
               end else if (bus.start) state_n = PAUSE;
        PAUSE: if (bus.start) state_n = RUN;
        ALARM: if (bus.pulse_1Hz) begin
                 if (tick == 8'(ALARM_SECS - 1)) begin
                   tick_n  = '0;
                   state_n = last ? DONE : LOAD;
                   idx_n   = last ? idx : idx + 2'd1;
                 end else tick_n = tick + 8'd1;
               end
        DONE:  if (bus.start) begin
                 state_n = IDLE;
                 idx_n   = '0;
               end
        default: state_n = IDLE;
      endcase
  end
  // abort clears outputs on the same edge that returns the FSM to IDLE
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      load_stb_q <= 1'b0;
      load_q     <= '0;
      en_q       <= 1'b0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      alarm_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      load_stb_q <= !bus.abort && state == LOAD;
      load_q     <= !bus.abort && state == LOAD ? cur_bcd : '0;
      en_q       <= !bus.abort && state == RUN;
      idx_q      <= bus.abort ? 2'd0 : idx;
      busy_q     <= !bus.abort && state inside {LOAD, RUN, PAUSE, ALARM};
      paused_q   <= !bus.abort && state == PAUSE;
      alarm_q    <= !bus.abort && (state == ALARM || (state == DONE && (alarm_q ^ bus.pulse_1Hz)));
      done_q     <= !bus.abort && state == DONE;
    end
  assign bus.timer_load   = load_stb_q;
  assign bus.load_bcd     = load_q;
  assign bus.timer_enable = en_q;
  assign bus.stage_idx    = idx_q;
  assign bus.busy         = busy_q;
  assign bus.paused       = paused_q;
  assign bus.alarm        = alarm_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_cook_program_sequencer.sv
// tb_cook_program_sequencer: directed scenarios plus random traffic against a phase-level reference model
module tb_cook_program_sequencer;
  localparam int NS = 4;
  localparam int AS = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  cook_program_sequencer_if bus();
  cook_program_sequencer #(.NUM_STAGES(NS), .ALARM_SECS(AS)) dut (
    .CLK100MHZ(clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );
  always #5 clk = ~clk;
  // reference model: program phase by name, stage number, seconds of alarm heard so far
  string mode;
  int cur, ticks;
  bit fresh;
  logic [15:0] prog [5];
  logic ex_err, ex_load, ex_en, ex_busy, ex_paused, ex_alarm, ex_done;
  logic [15:0] ex_bcd;
  logic [1:0] ex_idx;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit bcd_valid(input logic [15:0] v);
    int d [4];
    for (int k = 0; k < 4; k++) d[k] = int'((v >> (4 * k)) % 16);
    return d[3] < 10 && d[2] < 10 && d[1] < 6 && d[0] < 10;
  endfunction
  task automatic model_reset;
    for (int k = 0; k < 5; k++) prog[k] = 16'h0;
    mode = "idle"; cur = 0; ticks = 0; fresh = 0;
    {ex_err, ex_load, ex_en, ex_busy, ex_paused, ex_alarm, ex_done} = '0;
    ex_bcd = 16'h0; ex_idx = 2'd0;
  endtask
  task automatic model(input bit st, ab, pl, tz, we, input logic [1:0] ad, input logic [15:0] dt);
    bit acc;
    acc = 0;
    ex_err = 0;
    if (we && !ab && mode == "idle" && int'(ad) < NS) begin
      if (bcd_valid(dt)) acc = 1;
      else ex_err = 1;
    end
    ex_load   = !ab && mode == "load";
    ex_bcd    = ex_load ? prog[cur] : 16'h0;
    ex_en     = !ab && mode == "run";
    ex_idx    = ab ? 2'd0 : 2'(cur);
    ex_busy   = !ab && (mode == "load" || mode == "run" || mode == "pause" || mode == "alarm");
    ex_paused = !ab && mode == "pause";
    ex_alarm  = !ab && (mode == "alarm" || (mode == "done" && (ex_alarm ^ pl)));
    ex_done   = !ab && mode == "done";
    if (ab) begin
      mode = "idle"; cur = 0; ticks = 0; fresh = 0;
    end else if (mode == "idle") begin
      if (st && prog[0] != 0) begin mode = "load"; cur = 0; end
    end else if (mode == "load") begin
      mode = "run"; fresh = 1;
    end else if (mode == "run") begin
      if (!fresh && tz) begin mode = "alarm"; ticks = 0; end
      else if (st) mode = "pause";
      fresh = 0;
    end else if (mode == "pause") begin
      if (st) mode = "run";
    end else if (mode == "alarm") begin
      if (pl) begin
        ticks++;
        if (ticks == AS) begin
          ticks = 0;
          if (cur == NS - 1 || prog[cur + 1] == 0) mode = "done";
          else begin cur++; mode = "load"; end
        end
      end
    end else if (mode == "done") begin
      if (st) begin mode = "idle"; cur = 0; end
    end
    if (acc) prog[ad] = dt;
  endtask
  task automatic compare_all;
    check("prog_err", bus.prog_err, ex_err);
    check("timer_load", bus.timer_load, ex_load);
    check("load_bcd", bus.load_bcd, ex_bcd);
    check("timer_enable", bus.timer_enable, ex_en);
    check("stage_idx", bus.stage_idx, ex_idx);
    check("busy", bus.busy, ex_busy);
    check("paused", bus.paused, ex_paused);
    check("alarm", bus.alarm, ex_alarm);
    check("done", bus.done, ex_done);
  endtask
  task automatic step(input bit st, ab, pl, tz, we, input logic [1:0] ad, input logic [15:0] dt);
    bus.start = st; bus.abort = ab; bus.pulse_1Hz = pl; bus.timer_zero = tz;
    bus.prog_we = we; bus.prog_addr = ad; bus.prog_data = dt;
    @(posedge clk);
    model(st, ab, pl, tz, we, ad, dt);
    @(negedge clk);
    compare_all();
  endtask
  task automatic nop;                 step(0, 0, 0, 0, 0, 2'd0, 16'h0); endtask
  task automatic go;                  step(1, 0, 0, 0, 0, 2'd0, 16'h0); endtask
  task automatic pulse;               step(0, 0, 1, 0, 0, 2'd0, 16'h0); endtask
  task automatic zero;                step(0, 0, 0, 1, 0, 2'd0, 16'h0); endtask
  task automatic kill;                step(0, 1, 0, 0, 0, 2'd0, 16'h0); endtask
  task automatic wr(input logic [1:0] ad, input logic [15:0] dt); step(0, 0, 0, 0, 1, ad, dt); endtask
  initial begin
    bit st, ab, pl, tz, we;
    logic [1:0] ad;
    logic [15:0] dt;
    {bus.start, bus.abort, bus.pulse_1Hz, bus.timer_zero, bus.prog_we} = '0;
    bus.prog_addr = 2'd0; bus.prog_data = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    // program two stages, reject bad BCD
    wr(2'd0, 16'h0130);
    wr(2'd1, 16'h0045);
    wr(2'd0, 16'h0075);
    check("err_0075", bus.prog_err, 1);
    nop();
    check("err_one_cycle", bus.prog_err, 0);
    wr(2'd1, 16'h0A00);
    check("err_0A00", bus.prog_err, 1);
    // start -> load of stage0 two cycles later
    go();
    nop();
    check("ld0_stb", bus.timer_load, 1);
    check("ld0_bcd", bus.load_bcd, 16'h0130);
    wr(2'd0, 16'h0999);
    check("busy_wr_no_err", bus.prog_err, 0);
    zero();
    nop();
    check("alarm_on", bus.alarm, 1);
    pulse(); pulse();
    check("alarm_held", bus.alarm, 1);
    pulse();
    nop();
    check("ld1_bcd", bus.load_bcd, 16'h0045);
    check("ld1_idx", bus.stage_idx, 2'd1);
    nop(); zero(); pulse(); pulse(); pulse(); nop();
    check("two_stage_done", bus.done, 1);
    go(); nop();
    go(); nop();
    check("busy_wr_kept", bus.load_bcd, 16'h0130);
    // pause and resume without reload
    nop(); nop();
    go(); nop();
    check("pause_paused", bus.paused, 1);
    check("pause_en", bus.timer_enable, 0);
    go(); nop();
    check("resume_en", bus.timer_enable, 1);
    check("resume_noload", bus.timer_load, 0);
    // timer_zero beats start
    step(1, 0, 0, 1, 0, 2'd0, 16'h0);
    nop();
    check("coinc_alarm", bus.alarm, 1);
    check("coinc_paused", bus.paused, 0);
    kill();
    // abort beats start in IDLE
    step(1, 1, 0, 0, 0, 2'd0, 16'h0);
    nop();
    check("abort_start_idle", bus.busy, 0);
    // four stages through to DONE
    wr(2'd0, 16'h0001); wr(2'd1, 16'h0002); wr(2'd2, 16'h0003); wr(2'd3, 16'h0004);
    go();
    for (int s = 0; s < NS; s++) begin
      nop(); nop(); zero(); pulse(); pulse(); pulse();
    end
    nop();
    check("done4", bus.done, 1);
    check("done4_idx", bus.stage_idx, 2'd3);
    pulse();
    check("done_toggle0", bus.alarm, 0);
    pulse();
    check("done_toggle1", bus.alarm, 1);
    go(); nop();
    check("done_clear", bus.done, 0);
    // asynchronous reset mid-RUN
    go(); nop(); nop();
    #2 reset_n = 1'b0;
    #1;
    check("arst_en", bus.timer_enable, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_idx", bus.stage_idx, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    go(); nop();
    check("arst_start_ignored", bus.busy, 0);
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      st = $urandom_range(0, 7) == 0;
      ab = $urandom_range(0, 99) == 0;
      pl = $urandom_range(0, 3) == 0;
      tz = $urandom_range(0, 5) == 0;
      we = $urandom_range(0, 3) == 0;
      ad = 2'($urandom_range(0, 3));
      dt = $urandom_range(0, 7) == 0 ? 16'($urandom) :
           $urandom_range(0, 5) == 0 ? 16'h0 :
           {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      step(st, ab, pl, tz, we, ad, dt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
